// File: rtl/ntr_resp_path_if.sv
// Signal bundle between the NTR response datapath and its surroundings:
// NTR clock, serialiser handshake/data and the UART byte FIFO.
interface ntr_resp_path_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  ntr_clk_raw;
  logic                  ntr_clk_db;
  logic                  ready;
  logic                  word_load;
  logic [31:0]           data_word;
  logic [7:0]            ntr_data_out;
  logic                  request_word;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;

  modport master (
    output ntr_clk_raw, ready, word_load, data_word, wr_en, wr_data, rd_en,
    input  ntr_clk_db, ntr_data_out, request_word, rd_data, empty, full
  );

  modport slave (
    input  ntr_clk_raw, ready, word_load, data_word, wr_en, wr_data, rd_en,
    output ntr_clk_db, ntr_data_out, request_word, rd_data, empty, full
  );
endinterface

// File: rtl/ntr_resp_path.sv
// NTR response datapath: NTR clock debouncer, 32-bit word to byte serialiser
// and a first-word-fall-through byte FIFO for UART-received data.
module ntr_resp_path #(
  parameter int   DATA_WIDTH    = 8,
  parameter int   ADDRESS_WIDTH = 9,
  parameter logic DB_INIT       = 1'b0,
  parameter int   DB_LEN        = 2
) (
  input  logic            clk,
  input  logic            reset,
  ntr_resp_path_if.slave  bus
);
  localparam int DB_CW = $clog2(DB_LEN + 1);
  localparam int AW    = ADDRESS_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic             db_q, db_d;
  logic [DB_CW-1:0] db_cnt_q, db_cnt_d;
  logic             db_prev_q;
  logic             rise_s;

  logic             ready_prev_q;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       dout_q, dout_d;
  logic             req_q, req_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             do_wr_s, do_rd_s;

  // Debouncer: follow the raw clock only after DB_LEN consecutive differing samples
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (bus.ntr_clk_raw != db_q) begin
      if (db_cnt_q == DB_CW'(DB_LEN - 1)) begin
        db_d     = bus.ntr_clk_raw;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_CW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Serialiser: byte index, word register, output byte and word request
  always_comb begin
    rise_s = db_q & ~db_prev_q;
    word_d = bus.word_load ? bus.data_word : word_q;
    idx_d  = idx_q;
    req_d  = 1'b0;
    if (!bus.ready) begin
      idx_d = 2'd0;
      req_d = 1'b0;
    end else begin
      if (rise_s) begin
        idx_d = idx_q + 2'd1;
      end else begin
        idx_d = idx_q;
      end
      req_d = ~ready_prev_q | (rise_s & (idx_q == 2'd3));
    end
    case (idx_q)
      2'd0:    dout_d = word_q[7:0];
      2'd1:    dout_d = word_q[15:8];
      2'd2:    dout_d = word_q[23:16];
      2'd3:    dout_d = word_q[31:24];
      default: dout_d = word_q[7:0];
    endcase
  end

  // FIFO pointer and flag next state; a full FIFO still accepts a write paired with a read
  always_comb begin
    do_wr_s  = bus.wr_en & (~full_q | bus.rd_en);
    do_rd_s  = bus.rd_en & ~empty_q;
    wr_ptr_d = do_wr_s ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_rd_s ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q         <= DB_INIT;
      db_cnt_q     <= '0;
      db_prev_q    <= DB_INIT;
      ready_prev_q <= 1'b0;
      idx_q        <= 2'd0;
      word_q       <= 32'd0;
      dout_q       <= 8'd0;
      req_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
    end else begin
      db_q         <= db_d;
      db_cnt_q     <= db_cnt_d;
      db_prev_q    <= db_q;
      ready_prev_q <= bus.ready;
      idx_q        <= idx_d;
      word_q       <= word_d;
      dout_q       <= dout_d;
      req_q        <= req_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
    end
  end

  // FIFO storage carries no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
    end
  end

  assign bus.ntr_clk_db   = db_q;
  assign bus.ntr_data_out = dout_q;
  assign bus.request_word = req_q;
  assign bus.rd_data      = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
endmodule

// File: tb/tb_ntr_resp_path.sv
// Scoreboard bench for ntr_resp_path: timed expectations for the serialiser and
// debouncer, and a queue model of the FIFO checked every cycle by a monitor.
`timescale 1ns/1ps
module tb_ntr_resp_path;
  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int DBL   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ntr_resp_path_if #(.DATA_WIDTH(DW)) bus ();

  ntr_resp_path #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DB_INIT(1'b0), .DB_LEN(DBL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         req_due[$];
  logic [7:0] fifo_m[$];

  int          k;
  logic [31:0] w;
  logic        mon_req;
  bit          acc_wr, acc_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] word, input int n);
    return word[8*n +: 8];
  endfunction

  task automatic push_exp(input int due, input int kind, input logic [31:0] val);
    exp_t e;
    e.due = due; e.kind = kind; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare everything the DUT presents against the bench's expectations
  always @(negedge clk) begin
    if (started) begin
      mon_req = 1'b0;
      if (req_due.size() > 0 && req_due[0] == cyc) begin
        mon_req = 1'b1;
        void'(req_due.pop_front());
      end
      chk("request_word", bus.request_word, mon_req);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].due <= cyc) begin
          if (exp_q[i].kind == 0) chk("ntr_data_out", bus.ntr_data_out, exp_q[i].val);
          else                    chk("ntr_clk_db", bus.ntr_clk_db, exp_q[i].val);
          exp_q.delete(i);
        end
      end
      chk("empty", bus.empty, fifo_m.size() == 0);
      chk("full", bus.full, fifo_m.size() == DEPTH);
      if (fifo_m.size() > 0) chk("rd_data", bus.rd_data, fifo_m[0]);
      if (reset) begin
        fifo_m.delete();
      end else begin
        acc_rd = bus.rd_en && fifo_m.size() > 0;
        acc_wr = bus.wr_en && (fifo_m.size() < DEPTH || acc_rd);
        if (acc_rd) void'(fifo_m.pop_front());
        if (acc_wr) fifo_m.push_back(bus.wr_data);
      end
    end
  end

  task automatic raise_ready();
    int t;
    t = cyc;
    bus.ready = 1'b1;
    req_due.push_back(t + 1);
    step(2);
  endtask

  task automatic drop_ready();
    int t;
    t = cyc;
    bus.ready = 1'b0;
    k = 0;
    push_exp(t + 2, 0, byte_of(w, 0));
    step(3);
  endtask

  task automatic load_word(input logic [31:0] nw);
    int t;
    t = cyc;
    bus.word_load = 1'b1;
    bus.data_word = nw;
    w = nw;
    push_exp(t + 2, 0, byte_of(w, k));
    step(1);
    bus.word_load = 1'b0;
    step(2);
  endtask

  // One clean NTR clock pulse; optionally load a new word in the cycle the rise is seen
  task automatic ntr_pulse(input bit ld, input logic [31:0] nw);
    int t;
    t = cyc;
    bus.ntr_clk_raw = 1'b1;
    step(DBL);
    if (ld) begin
      bus.word_load = 1'b1;
      bus.data_word = nw;
      w = nw;
    end
    step(1);
    bus.word_load = 1'b0;
    k = (k + 1) % 4;
    if (k == 0) req_due.push_back(t + DBL + 1);
    push_exp(t + DBL + 2, 0, byte_of(w, k));
    bus.ntr_clk_raw = 1'b0;
    step(DBL + 2);
  endtask

  task automatic fifo_op(input bit wr, input logic [7:0] d, input bit rd);
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    step(1);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    int t;
    int wait_cnt;
    bus.ntr_clk_raw = 1'b0;
    bus.ready       = 1'b0;
    bus.word_load   = 1'b0;
    bus.data_word   = 32'd0;
    bus.wr_en       = 1'b0;
    bus.wr_data     = 8'd0;
    bus.rd_en       = 1'b0;
    k = 0;
    w = 32'd0;
    step(3);
    reset = 1'b0;
    chk("reset ntr_clk_db", bus.ntr_clk_db, 1'b0);
    chk("reset ntr_data_out", bus.ntr_data_out, 8'h00);
    chk("reset request_word", bus.request_word, 1'b0);
    chk("reset empty", bus.empty, 1'b1);
    chk("reset full", bus.full, 1'b0);
    started = 1'b1;

    // glitch shorter than DB_LEN is suppressed
    t = cyc;
    bus.ntr_clk_raw = 1'b1;
    step(1);
    bus.ntr_clk_raw = 1'b0;
    for (int i = 1; i <= 5; i++) push_exp(t + i, 1, 1'b0);
    step(6);
    // clean high for DB_LEN samples, then back low
    t = cyc;
    bus.ntr_clk_raw = 1'b1;
    push_exp(t + DBL - 1, 1, 1'b0);
    push_exp(t + DBL, 1, 1'b1);
    step(DBL);
    bus.ntr_clk_raw = 1'b0;
    push_exp(t + 2*DBL - 1, 1, 1'b1);
    push_exp(t + 2*DBL, 1, 1'b0);
    step(2*DBL + 2);

    // directed serialiser word
    raise_ready();
    load_word(32'h807F01E0);
    for (int i = 0; i < 4; i++) ntr_pulse(1'b0, 32'd0);
    ntr_pulse(1'b0, 32'd0);
    ntr_pulse(1'b0, 32'd0);
    drop_ready();
    raise_ready();

    // randomised serialiser rounds
    for (int r = 0; r < 10; r++) begin
      load_word($urandom);
      for (int p = 0; p < int'($urandom_range(1, 6)); p++)
        ntr_pulse(($urandom % 4) == 0, $urandom);
      if (($urandom % 3) == 0) begin
        drop_ready();
        raise_ready();
      end
    end
    drop_ready();

    // FIFO: small write/read
    fifo_op(1'b1, 8'h11, 1'b0);
    fifo_op(1'b1, 8'h22, 1'b0);
    fifo_op(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 3; i++) fifo_op(1'b0, 8'h00, 1'b1);
    step(1);
    // fill, overflow attempt, drain, underflow attempt
    for (int i = 0; i < DEPTH; i++) fifo_op(1'b1, 8'($urandom), 1'b0);
    fifo_op(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < DEPTH; i++) fifo_op(1'b0, 8'h00, 1'b1);
    fifo_op(1'b0, 8'h00, 1'b1);
    fifo_op(1'b0, 8'h00, 1'b1);
    // simultaneous on empty
    fifo_op(1'b1, 8'h5C, 1'b1);
    fifo_op(1'b0, 8'h00, 1'b1);
    step(1);
    // simultaneous on full
    for (int i = 0; i < DEPTH; i++) fifo_op(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) fifo_op(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < DEPTH; i++) fifo_op(1'b0, 8'h00, 1'b1);
    // random traffic with drifting bias
    for (int i = 0; i < 1500; i++) begin
      if (i < 500)       fifo_op(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) == 0);
      else if (i < 1000) fifo_op(($urandom % 2) == 0, 8'($urandom), ($urandom % 2) == 0);
      else               fifo_op(($urandom % 4) == 0, 8'($urandom), ($urandom % 4) != 0);
    end
    // reset with entries present
    for (int i = 0; i < DEPTH; i++) fifo_op(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) fifo_op(1'b1, 8'($urandom), 1'b0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("empty after reset", bus.empty, 1'b1);
    chk("ntr_data_out after reset", bus.ntr_data_out, 8'h00);
    step(3);

    wait_cnt = 0;
    while ((exp_q.size() > 0 || req_due.size() > 0) && wait_cnt < 100) begin
      step(1);
      wait_cnt++;
    end
    total++;
    if (exp_q.size() > 0 || req_due.size() > 0) begin
      bad++;
      $display("FAIL scoreboard drain: pending=%0d required=0", exp_q.size() + req_due.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ntr_resp_path.md
Name: ntr_resp_path

Overview:
- Single-clock response datapath for the NTR (DS cartridge) bus.
- Debounces the raw NTR bus clock and buffers UART-received bytes in a synchronous FIFO.
- Serialises 32-bit response words onto the 8-bit NTR data bus one byte per NTR clock edge.
- Sits between the UART receiver / command FSM and the bidirectional NTR data pad driver.

Parameters:
- DATA_WIDTH, 8: FIFO word width.
- ADDRESS_WIDTH, 9: FIFO address bits; depth = 2^ADDRESS_WIDTH (512).
- DB_INIT, 0: debounced-clock reset value.
- DB_LEN, 2: consecutive identical samples required before the debounced output follows the input (minimum 1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ntr_clk_raw  in  1  raw NTR bus clock, already synchronised to clk.
- ntr_clk_db  out  1  debounced NTR clock.
- ready  in  1  high while a decoded command is active and the card drives data.
- word_load  in  1  loads data_word into the serialiser word register.
- data_word  in  32  response word; byte 0 = bits [7:0].
- ntr_data_out  out  8  byte presented to the pad driver.
- request_word  out  1  one-cycle pulse requesting the next word.
- wr_en  in  1  FIFO write strobe.
- wr_data  in  DATA_WIDTH  FIFO write data.
- rd_en  in  1  FIFO pop strobe.
- rd_data  out  DATA_WIDTH  FIFO head (first-word-fall-through).
- empty  out  1  FIFO empty flag.
- full  out  1  FIFO full flag.

Behaviour:
Reset:
- ntr_clk_db = DB_INIT.
- Byte index = 0.
- Word register = 0.
- ntr_data_out = 0.
- request_word = 0.
- FIFO pointers = 0, so empty = 1 and full = 0.
- A reset asserted mid-operation discards FIFO contents and any in-progress word.

Debouncer:
- Samples ntr_clk_raw every clk.
- Keeps a counter of consecutive samples that differ from ntr_clk_db.
- When the counter reaches DB_LEN, ntr_clk_db takes the sampled value and the counter clears.
- Any sample equal to ntr_clk_db clears the counter.
- Latency for a clean transition is DB_LEN cycles; glitches shorter than DB_LEN cycles are suppressed.

Edge detect:
- Registered previous value of ntr_clk_db.
- rise = ntr_clk_db & ~prev.

Serialiser:
- ntr_data_out is registered and always equals byte[idx] of the word register.
- ready low: idx held at 0 and request_word held at 0.
- ready 0 -> 1 transition: request_word pulses for exactly one cycle.
- On a rise while ready = 1: idx advances 0->1->2->3->0.
- On the rise that wraps 3 -> 0: request_word pulses for exactly one cycle.
- word_load = 1: word register <= data_word on that cycle. If it coincides with a rise, the load applies and idx still advances.
- ntr_data_out reflects an idx or word change one cycle after it.

FIFO (synchronous, first-word-fall-through):
- rd_data shows the oldest entry whenever empty = 0; value is undefined when empty.
- Write with full = 1 is ignored (no overwrite).
- Read with empty = 1 is ignored.
- Simultaneous read and write when non-empty and non-full: both occur; occupancy unchanged.
- Simultaneous read and write when full: both occur; full stays 1.
- Simultaneous read and write when empty: write accepted, read ignored; empty deasserts next cycle.
- Flags are registered and update the cycle after the operation.
- full when occupancy = 2^ADDRESS_WIDTH.
- Pointers wrap modulo depth.

Test Plan:
- Reset, then hold ntr_clk_raw = 1 for 1 cycle, then 0 -> ntr_clk_db stays 0. Hold 1 for 2 cycles -> ntr_clk_db = 1 exactly 2 cycles after the first high sample.
- ready 0 -> 1 -> request_word pulses once. word_load with data_word = 0x807F01E0 -> ntr_data_out = 0xE0. Next three NTR clock rises -> 0x01, 0x7F, 0x80. Fourth rise -> request_word pulse and idx = 0.
- ready drops mid-word at idx = 2 -> idx returns to 0, no request_word pulse. Re-raise ready -> single request_word pulse.
- Write 0x11, 0x22, 0x33 -> empty = 0, rd_data = 0x11. Three rd_en pulses -> rd_data 0x22, then 0x33, then empty = 1.
- Write 512 bytes -> full = 1. 513th write ignored. Read 512 -> original order, empty = 1. Extra rd_en is ignored and the pointer does not move.
- Simultaneous wr_en + rd_en: on an empty FIFO -> only the write lands. On a full FIFO -> full stays 1 and order is preserved. Reset asserted with 5 entries -> empty = 1 next cycle.
